// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one bitwise gate unit.
// The grant is offered in IDLE; the result appears two cycles later and is held until accepted.
module gate_unit_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    input  logic [N_REQ*2-1:0]       req_op,
    output logic [N_REQ-1:0]         gnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic [$clog2(N_REQ)-1:0] out_id
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [ID_W-1:0]   ptr, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic              valid_d;
    logic [WIDTH-1:0]  y_d;
    logic [ID_W-1:0]   out_id_d;
    logic [N_REQ-1:0]  gnt_d;
    logic              found;
    logic [ID_W-1:0]   sel, cand;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    function automatic logic [WIDTH-1:0] gate_op(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // First active requester at or above ptr, wrapping to 0.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = wrap_add(ptr, i);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        valid_d  = out_valid;
        y_d      = out_y;
        out_id_d = out_id;
        gnt_d    = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_d   = N_REQ'(1) << sel;
                    a_d     = req_a[32'(sel)*WIDTH +: WIDTH];
                    b_d     = req_b[32'(sel)*WIDTH +: WIDTH];
                    op_d    = req_op[32'(sel)*2 +: 2];
                    id_d    = sel;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                y_d      = gate_op(op_q, a_q, b_q);
                out_id_d = id_q;
                valid_d  = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = wrap_add(out_id, 1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The grant is a same-cycle offer, so it is forced low while reset is held.
    assign gnt = rst_n ? gnt_d : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_id    <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            out_valid <= valid_d;
            out_y     <= y_d;
            out_id    <= out_id_d;
        end
    end

endmodule
